register_file: RTL and testbench



---
 rtl/mips_pkg.sv | 18 +
 rtl/regfile_read_port.sv | 30 +++
 rtl/register_file.sv | 59 +++++
 tb/tb_register_file.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-index width, data width and the
// index of the hardwired-zero register. Used by the register file, the
// datapath and the hazard unit.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // True when a write with these controls would really land in a register
  function automatic logic writeTakesEffect(input logic regWriteCtrl,
                                            input logic [REG_ADDR_W-1:0] writeReg);
    return regWriteCtrl && (writeReg != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file, including the
// same-cycle write-to-read bypass and the hardwired-zero register.
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int DW = mips_pkg::DATA_W,
  parameter int AW = mips_pkg::REG_ADDR_W
) (
  input  logic                     rst,
  input  logic [AW-1:0]            readReg,
  input  logic [2**AW-1:1][DW-1:0] regs,
  input  logic                     bypassEn,
  input  logic [AW-1:0]            writeReg,
  input  logic [DW-1:0]            writeData,
  output logic [DW-1:0]            readData
);

  // Reset forces zero; a pending WB write to the same index wins over storage
  always_comb begin
    readData = '0;
    if (!rst) begin
      if (bypassEn && (readReg == writeReg)) begin
        readData = writeData;
      end else if (readReg != '0) begin
        readData = regs[readReg];
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// MIPS general-purpose register file: 32 x 32-bit, two combinational read
// ports for ID, one synchronous write port from WB, r0 hardwired to zero,
// and a WB-to-ID bypass so a read sees the value being written this cycle.
module register_file
  import mips_pkg::*;
#(
  parameter int DW = mips_pkg::DATA_W,
  parameter int AW = mips_pkg::REG_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ReadReg1,
  input  logic [AW-1:0] ReadReg2,
  input  logic [AW-1:0] WriteReg,
  input  logic [DW-1:0] WriteData,
  input  logic          RegWrite_ctrl,
  output logic [DW-1:0] ReadData1,
  output logic [DW-1:0] ReadData2
);

  // r0 has no storage; entries 1..31 only
  logic [2**AW-1:1][DW-1:0] regs;
  logic                     writeEn;

  // A write to index 0 is discarded, so it must not bypass either
  always_comb begin
    writeEn = RegWrite_ctrl && (WriteReg != '0);
  end

  // Storage: async clear, then one write per edge from WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (writeEn) begin
      regs[WriteReg] <= WriteData;
    end
  end

  regfile_read_port #(.DW(DW), .AW(AW)) uReadPort1 (
    .rst       (rst),
    .readReg   (ReadReg1),
    .regs      (regs),
    .bypassEn  (writeEn),
    .writeReg  (WriteReg),
    .writeData (WriteData),
    .readData  (ReadData1)
  );

  regfile_read_port #(.DW(DW), .AW(AW)) uReadPort2 (
    .rst       (rst),
    .readReg   (ReadReg2),
    .regs      (regs),
    .bypassEn  (writeEn),
    .writeReg  (WriteReg),
    .writeData (WriteData),
    .readData  (ReadData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by
// random traffic, compared against a simple array model of the registers.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite_ctrl;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  logic [31:0] model [32];
  int nChecks = 0;
  int nFail   = 0;

  register_file dut (
    .clk           (clk),
    .rst           (rst),
    .ReadReg1      (ReadReg1),
    .ReadReg2      (ReadReg2),
    .WriteReg      (WriteReg),
    .WriteData     (WriteData),
    .RegWrite_ctrl (RegWrite_ctrl),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value derived from the register-file rules
  function automatic logic [31:0] expRead(input logic [4:0] idx);
    if (rst) return 32'd0;
    if (RegWrite_ctrl && WriteReg != 5'd0 && idx == WriteReg) return WriteData;
    if (idx == 5'd0) return 32'd0;
    return model[idx];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkReads(input string tag);
    #1;
    chk({tag, "_rd1"}, ReadData1, expRead(ReadReg1));
    chk({tag, "_rd2"}, ReadData2, expRead(ReadReg2));
  endtask

  // Advance one rising edge and commit the same write to the model
  task automatic tick();
    @(posedge clk);
    if (!rst && RegWrite_ctrl && WriteReg != 5'd0) model[WriteReg] = WriteData;
    #1;
  endtask

  task automatic checkAllRegs(input string tag);
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      #1;
      chk(tag, ReadData1, (i == 0) ? 32'd0 : model[i]);
      chk(tag, ReadData2, (i == 31) ? 32'd0 : model[31 - i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    rst = 1'b1;
    RegWrite_ctrl = 1'b0;
    WriteReg = '0;
    WriteData = '0;
    ReadReg1 = '0;
    ReadReg2 = '0;
    #12;

    // Reads during reset are zero, bypass suppressed
    RegWrite_ctrl = 1'b1;
    WriteReg = 5'd7;
    WriteData = 32'hCAFE_F00D;
    ReadReg1 = 5'd7;
    ReadReg2 = 5'd31;
    checkReads("in_reset");
    chk("in_reset_bypass_off", ReadData1, 32'd0);
    tick();
    RegWrite_ctrl = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkAllRegs("after_reset");

    // Bypass before the edge, storage after
    @(negedge clk);
    RegWrite_ctrl = 1'b1;
    WriteReg = 5'd1;
    WriteData = 32'h0000_ABCD;
    ReadReg1 = 5'd1;
    ReadReg2 = 5'd2;
    checkReads("wr1_pre");
    chk("wr1_bypass", ReadData1, 32'h0000_ABCD);
    chk("wr1_rd2_zero", ReadData2, 32'd0);
    tick();
    RegWrite_ctrl = 1'b0;
    checkReads("wr1_post");
    chk("wr1_stored", ReadData1, 32'h0000_ABCD);

    // Second register, r0 read, r1 untouched
    @(negedge clk);
    RegWrite_ctrl = 1'b1;
    WriteReg = 5'd2;
    WriteData = 32'h0000_1234;
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd2;
    checkReads("wr2_pre");
    chk("wr2_bypass", ReadData2, 32'h0000_1234);
    tick();
    RegWrite_ctrl = 1'b0;
    ReadReg1 = 5'd1;
    checkReads("wr2_post");
    chk("r1_kept", ReadData1, 32'h0000_ABCD);

    // Write to r0 is discarded and never bypassed
    @(negedge clk);
    RegWrite_ctrl = 1'b1;
    WriteReg = 5'd0;
    WriteData = 32'hFFFF_FFFF;
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;
    checkReads("r0_pre");
    chk("r0_pre_zero", ReadData1, 32'd0);
    tick();
    RegWrite_ctrl = 1'b0;
    checkReads("r0_post");
    chk("r0_post_zero", ReadData2, 32'd0);

    // Write disabled: no change, no bypass
    @(negedge clk);
    RegWrite_ctrl = 1'b0;
    WriteReg = 5'd1;
    WriteData = 32'h0000_DEAD;
    ReadReg1 = 5'd1;
    ReadReg2 = 5'd1;
    checkReads("we0_pre");
    chk("we0_no_bypass", ReadData1, 32'h0000_ABCD);
    tick();
    checkReads("we0_post");
    chk("we0_kept", ReadData2, 32'h0000_ABCD);

    // Index 31, then back-to-back writes to one register
    @(negedge clk);
    RegWrite_ctrl = 1'b1;
    WriteReg = 5'd31;
    WriteData = 32'h3131_3131;
    ReadReg1 = 5'd31;
    ReadReg2 = 5'd31;
    checkReads("r31_pre");
    tick();
    WriteData = 32'h0BAD_BEEF;
    tick();
    RegWrite_ctrl = 1'b0;
    checkReads("r31_last_wins");
    chk("r31_last_wins_val", ReadData1, 32'h0BAD_BEEF);

    // X on indices with write disabled leaves state alone
    @(negedge clk);
    RegWrite_ctrl = 1'b0;
    WriteReg = 5'bxxxxx;
    WriteData = 32'hxxxx_xxxx;
    tick();
    WriteReg = 5'd0;
    WriteData = 32'd0;
    checkAllRegs("x_idx");

    // Async reset mid-cycle
    @(negedge clk);
    RegWrite_ctrl = 1'b1;
    WriteReg = 5'd5;
    WriteData = 32'h0000_0055;
    tick();
    RegWrite_ctrl = 1'b0;
    ReadReg1 = 5'd5;
    ReadReg2 = 5'd1;
    checkReads("r5_stored");
    chk("r5_val", ReadData1, 32'h0000_0055);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #1;
    chk("async_rst_r5", ReadData1, 32'd0);
    chk("async_rst_r1", ReadData2, 32'd0);
    RegWrite_ctrl = 1'b1;
    WriteReg = 5'd5;
    WriteData = 32'h5555_5555;
    tick();
    RegWrite_ctrl = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("no_write_in_rst", ReadData1, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      RegWrite_ctrl = 1'($urandom_range(0, 1));
      WriteReg = 5'($urandom);
      WriteData = $urandom;
      ReadReg1 = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom);
      ReadReg2 = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom);
      checkReads("rand");
      tick();
    end
    RegWrite_ctrl = 1'b0;
    checkAllRegs("final");

    $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
    $finish;
  end

endmodule
